// File: rtl/multi_ch_cal_ctrl_if.sv
// multi_ch_cal_ctrl_if: AFE control, LED drive and tagged sample stream of the calibration controller.
// master = controller side, slave = front end / downstream side.
interface multi_ch_cal_ctrl_if #(
    parameter int NUM_CH = 2,
    parameter int ADC_W  = 8,
    parameter int DC_W   = 7,
    parameter int PGA_W  = 4
);
    localparam int CHW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;

    logic              Find_setting;
    logic [ADC_W-1:0]  ADC;
    logic [NUM_CH-1:0] LED_EN;
    logic [DC_W-1:0]   DC_Comp;
    logic [PGA_W-1:0]  PGA_Gain;
    logic              CLK_Filter;
    logic              busy;
    logic              done;
    logic [NUM_CH-1:0] cal_fail;
    logic              sample_valid;
    logic [CHW-1:0]    sample_ch;
    logic [ADC_W-1:0]  sample_data;

    modport master (
        input  Find_setting, ADC,
        output LED_EN, DC_Comp, PGA_Gain, CLK_Filter, busy, done, cal_fail,
               sample_valid, sample_ch, sample_data
    );

    modport slave (
        output Find_setting, ADC,
        input  LED_EN, DC_Comp, PGA_Gain, CLK_Filter, busy, done, cal_fail,
               sample_valid, sample_ch, sample_data
    );
endinterface

// File: rtl/multi_ch_cal_ctrl.sv
// multi_ch_cal_ctrl: per-channel DC/PGA calibration by windowed min/max measurement,
// then round-robin LED time-multiplexing with stored settings and tagged sample strobes.
module multi_ch_cal_ctrl #(
    parameter int NUM_CH    = 2,
    parameter int ADC_W     = 8,
    parameter int DC_W      = 7,
    parameter int PGA_W     = 4,
    parameter int SETTLE    = 2,
    parameter int WIN       = 4,
    parameter int SLOT      = 10,
    parameter int TARGET_LO = 120,
    parameter int TARGET_HI = 130,
    parameter int CLIP_LO   = 10,
    parameter int CLIP_HI   = 245
) (
    input logic                 CLK,
    input logic                 rst_n,
    multi_ch_cal_ctrl_if.master bus
);
    localparam int CHW  = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam int MEAS = SETTLE + WIN;
    localparam int CNTW = $clog2((MEAS > SLOT ? MEAS : SLOT) + 1);
    localparam logic [DC_W-1:0]  DC_MID     = DC_W'(1 << (DC_W - 1));
    localparam logic [DC_W-1:0]  DC_MAX     = '1;
    localparam logic [PGA_W-1:0] PGA_MAX    = '1;
    localparam logic [ADC_W:0]   T_LO       = (ADC_W + 1)'(TARGET_LO);
    localparam logic [ADC_W:0]   T_HI       = (ADC_W + 1)'(TARGET_HI);
    localparam logic [ADC_W-1:0] C_LO       = ADC_W'(CLIP_LO);
    localparam logic [ADC_W-1:0] C_HI       = ADC_W'(CLIP_HI);
    localparam logic [CNTW-1:0]  SETTLE_END = CNTW'(SETTLE);
    localparam logic [CNTW-1:0]  MEAS_LAST  = CNTW'(MEAS - 1);
    localparam logic [CNTW-1:0]  SLOT_LAST  = CNTW'(SLOT - 1);
    localparam logic [CHW-1:0]   CH_LAST    = CHW'(NUM_CH - 1);

    typedef enum logic [2:0] {IDLE, DC_MEAS, DC_ADJ, PGA_MEAS, PGA_ADJ, RUN} state_t;

    state_t            state_q, state_d;
    logic [CHW-1:0]    ch_q, ch_d, smp_ch_q, smp_ch_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [ADC_W-1:0]  vmin_q, vmin_d, vmax_q, vmax_d, smp_data_q, smp_data_d;
    logic [DC_W-1:0]   dc_comp_q, dc_comp_d;
    logic [PGA_W-1:0]  pga_gain_q, pga_gain_d;
    logic [NUM_CH-1:0] led_q, led_d, fail_q, fail_d;
    logic              busy_q, busy_d, done_q, done_d, clkf_q;
    logic [DC_W-1:0]   dc_q [NUM_CH];
    logic [DC_W-1:0]   dc_d [NUM_CH];
    logic [PGA_W-1:0]  pga_q [NUM_CH];
    logic [PGA_W-1:0]  pga_d [NUM_CH];
    logic [ADC_W:0]    avg;
    logic              clip, slot_end;

    function automatic logic [NUM_CH-1:0] onehot(input logic [CHW-1:0] c);
        return NUM_CH'(1) << c;
    endfunction

    // One extra bit keeps vmax+vmin from overflowing before the halving.
    assign avg      = ({1'b0, vmax_q} + {1'b0, vmin_q}) >> 1;
    assign clip     = vmin_q <= C_LO || vmax_q >= C_HI;
    assign slot_end = state_q == RUN && cnt_q == SLOT_LAST;

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        cnt_d      = cnt_q;
        vmin_d     = vmin_q;
        vmax_d     = vmax_q;
        dc_comp_d  = dc_comp_q;
        pga_gain_d = pga_gain_q;
        led_d      = led_q;
        fail_d     = fail_q;
        busy_d     = busy_q;
        done_d     = done_q;
        smp_ch_d   = smp_ch_q;
        smp_data_d = smp_data_q;
        dc_d       = dc_q;
        pga_d      = pga_q;
        if (bus.Find_setting) begin
            state_d    = DC_MEAS;
            ch_d       = '0;
            cnt_d      = '0;
            vmin_d     = '1;
            vmax_d     = '0;
            dc_comp_d  = DC_MID;
            pga_gain_d = '0;
            led_d      = onehot('0);
            fail_d     = '0;
            busy_d     = 1'b1;
            done_d     = 1'b0;
        end else begin
            case (state_q)
                DC_MEAS, PGA_MEAS: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q >= SETTLE_END) begin
                        vmin_d = bus.ADC < vmin_q ? bus.ADC : vmin_q;
                        vmax_d = bus.ADC > vmax_q ? bus.ADC : vmax_q;
                    end
                    if (cnt_q == MEAS_LAST) state_d = state_q == DC_MEAS ? DC_ADJ : PGA_ADJ;
                end
                DC_ADJ: begin
                    cnt_d  = '0;
                    vmin_d = '1;
                    vmax_d = '0;
                    if (avg < T_LO && dc_comp_q != '0) begin
                        dc_comp_d = dc_comp_q - 1'b1;
                        state_d   = DC_MEAS;
                    end else if (avg > T_HI && dc_comp_q != DC_MAX) begin
                        dc_comp_d = dc_comp_q + 1'b1;
                        state_d   = DC_MEAS;
                    end else begin
                        // Out of window here means the code is pinned at a rail.
                        dc_d[ch_q] = dc_comp_q;
                        if (avg < T_LO || avg > T_HI) fail_d[ch_q] = 1'b1;
                        state_d = PGA_MEAS;
                    end
                end
                PGA_ADJ: begin
                    cnt_d  = '0;
                    vmin_d = '1;
                    vmax_d = '0;
                    if (!clip && pga_gain_q != PGA_MAX) begin
                        pga_gain_d = pga_gain_q + 1'b1;
                        state_d    = PGA_MEAS;
                    end else begin
                        pga_d[ch_q] = !clip ? pga_gain_q : pga_gain_q == '0 ? '0 : pga_gain_q - 1'b1;
                        if (ch_q != CH_LAST) begin
                            ch_d       = ch_q + 1'b1;
                            led_d      = onehot(ch_q + 1'b1);
                            dc_comp_d  = DC_MID;
                            pga_gain_d = '0;
                            state_d    = DC_MEAS;
                        end else begin
                            // First slot settings come from the arrays as they are being written.
                            ch_d       = '0;
                            led_d      = onehot('0);
                            dc_comp_d  = dc_d[0];
                            pga_gain_d = pga_d[0];
                            busy_d     = 1'b0;
                            done_d     = 1'b1;
                            state_d    = RUN;
                        end
                    end
                end
                RUN: begin
                    cnt_d = cnt_q + 1'b1;
                    if (slot_end) begin
                        cnt_d      = '0;
                        smp_ch_d   = ch_q;
                        smp_data_d = bus.ADC;
                        ch_d       = ch_q == CH_LAST ? '0 : ch_q + 1'b1;
                        led_d      = onehot(ch_d);
                        dc_comp_d  = dc_q[ch_d];
                        pga_gain_d = pga_q[ch_d];
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ch_q       <= '0;
            cnt_q      <= '0;
            vmin_q     <= '1;
            vmax_q     <= '0;
            dc_comp_q  <= '0;
            pga_gain_q <= '0;
            led_q      <= '0;
            fail_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            smp_ch_q   <= '0;
            smp_data_q <= '0;
            dc_q       <= '{default: '0};
            pga_q      <= '{default: '0};
            clkf_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            cnt_q      <= cnt_d;
            vmin_q     <= vmin_d;
            vmax_q     <= vmax_d;
            dc_comp_q  <= dc_comp_d;
            pga_gain_q <= pga_gain_d;
            led_q      <= led_d;
            fail_q     <= fail_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            smp_ch_q   <= smp_ch_d;
            smp_data_q <= smp_data_d;
            dc_q       <= dc_d;
            pga_q      <= pga_d;
            clkf_q     <= ~clkf_q;
        end
    end

    // The strobe cycle presents the live sample; the capture holds it until the next strobe.
    assign bus.sample_valid = slot_end;
    assign bus.sample_ch    = slot_end ? ch_q : smp_ch_q;
    assign bus.sample_data  = slot_end ? bus.ADC : smp_data_q;
    assign bus.LED_EN       = led_q;
    assign bus.DC_Comp      = dc_comp_q;
    assign bus.PGA_Gain     = pga_gain_q;
    assign bus.CLK_Filter   = clkf_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.cal_fail     = fail_q;
endmodule

// File: tb/tb_multi_ch_cal_ctrl.sv
// tb_multi_ch_cal_ctrl: directed bench with an AFE model closing the DC/PGA loop around the controller.
module tb_multi_ch_cal_ctrl;
    logic CLK = 1'b0;
    logic rst_n = 1'b0;
    logic ph = 1'b0;
    int mode = 0;
    int checks = 0;
    int failures = 0;
    int tcur = 0;
    logic [7:0] held;

    always #5 CLK = ~CLK;
    always @(posedge CLK) ph <= ~ph;

    multi_ch_cal_ctrl_if bus ();
    multi_ch_cal_ctrl #(.WIN(4)) dut (.CLK(CLK), .rst_n(rst_n), .bus(bus));

    // Mode 0: RED centre 200-DC (+-8<<g), IR centre 170-DC (+-2<<g); 1: 128 +-8<<g; 2: 125; 3: 20.
    function automatic logic [7:0] afe(int m, logic p, logic [1:0] led, int dc, int g);
        int c, a, v;
        c = m == 0 ? (led[0] ? 200 : 170) - dc : m == 1 ? 128 : m == 2 ? 125 : 20;
        a = (m == 2 || m == 3) ? 0 : (m == 0 && !led[0] ? 2 : 8) << g;
        v = p ? c + a : c - a;
        return v > 255 ? 8'd255 : v < 0 ? 8'd0 : 8'(v);
    endfunction

    assign bus.ADC = afe(mode, ph, bus.LED_EN, int'(bus.DC_Comp), int'(bus.PGA_Gain));

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d (t=%0d)", tag, obs, exp, tcur);
        end
    endtask

    task automatic at(int t);
        repeat (t - tcur) @(negedge CLK);
        tcur = t;
    endtask

    task automatic start_cal(int m);
        mode = m;
        bus.Find_setting = 1'b1;
        @(negedge CLK);
        bus.Find_setting = 1'b0;
        tcur = 0;
    endtask

    initial begin
        bus.Find_setting = 1'b0;
        #12;
        chk("rst_led", bus.LED_EN, 0);
        chk("rst_dc", bus.DC_Comp, 0);
        chk("rst_pga", bus.PGA_Gain, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_fail", bus.cal_fail, 0);
        chk("rst_valid", bus.sample_valid, 0);
        chk("rst_clkf", bus.CLK_Filter, 0);
        @(negedge CLK);
        rst_n = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge CLK);
            chk("idle_clkf", bus.CLK_Filter, i % 2);
        end
        chk("idle_led", bus.LED_EN, 0);
        chk("idle_done", bus.done, 0);
        chk("idle_busy", bus.busy, 0);

        start_cal(0);
        chk("c0_dc", bus.DC_Comp, 64);
        chk("c0_led", bus.LED_EN, 1);
        chk("c0_busy", bus.busy, 1);
        chk("c0_done", bus.done, 0);
        for (int k = 1; k <= 6; k++) begin
            at(7 * k);
            chk("c0_dc_step", bus.DC_Comp, 64 + k);
        end
        at(49);
        chk("c0_dc_lock", bus.DC_Comp, 70);
        chk("c0_pga_start", bus.PGA_Gain, 0);
        chk("c0_fail", bus.cal_fail, 0);
        at(56);
        chk("c0_pga_step", bus.PGA_Gain, 1);
        chk("c0_dc_held", bus.DC_Comp, 70);
        at(84);
        chk("c0_ch1_led", bus.LED_EN, 2);
        chk("c0_ch1_dc", bus.DC_Comp, 64);
        chk("c0_ch1_pga", bus.PGA_Gain, 0);
        at(91);
        chk("c0_ch1_dc_dn", bus.DC_Comp, 63);
        at(189);
        chk("c0_ch1_dc_lock", bus.DC_Comp, 50);
        chk("c0_ch1_pga0", bus.PGA_Gain, 0);
        at(237);
        chk("c0_done_pre", bus.done, 0);
        at(238);
        chk("run_done", bus.done, 1);
        chk("run_busy", bus.busy, 0);
        chk("run_fail", bus.cal_fail, 0);
        chk("run_s0_led", bus.LED_EN, 1);
        chk("run_s0_dc", bus.DC_Comp, 70);
        chk("run_s0_pga", bus.PGA_Gain, 3);
        chk("run_valid_lo", bus.sample_valid, 0);
        at(246);
        chk("run_valid_lo2", bus.sample_valid, 0);
        at(247);
        held = afe(0, ph, 2'b01, 70, 3);
        chk("run_valid0", bus.sample_valid, 1);
        chk("run_ch0", bus.sample_ch, 0);
        chk("run_data0", bus.sample_data, held);
        at(248);
        chk("run_s1_led", bus.LED_EN, 2);
        chk("run_s1_dc", bus.DC_Comp, 50);
        chk("run_s1_pga", bus.PGA_Gain, 5);
        chk("run_valid_off", bus.sample_valid, 0);
        chk("run_hold_data", bus.sample_data, held);
        chk("run_hold_ch", bus.sample_ch, 0);
        at(257);
        chk("run_valid1", bus.sample_valid, 1);
        chk("run_ch1", bus.sample_ch, 1);
        chk("run_data1", bus.sample_data, afe(0, ph, 2'b10, 50, 5));
        at(258);
        chk("run_wrap_led", bus.LED_EN, 1);
        chk("run_wrap_dc", bus.DC_Comp, 70);
        at(263);

        start_cal(1);
        chk("rs_done", bus.done, 0);
        chk("rs_busy", bus.busy, 1);
        chk("rs_dc", bus.DC_Comp, 64);
        chk("rs_pga", bus.PGA_Gain, 0);
        chk("rs_led", bus.LED_EN, 1);
        at(7);
        chk("m1_dc_lock", bus.DC_Comp, 64);
        chk("m1_pga0", bus.PGA_Gain, 0);
        at(14);
        chk("m1_pga1", bus.PGA_Gain, 1);
        at(35);
        chk("m1_pga4", bus.PGA_Gain, 4);
        at(42);
        chk("m1_ch1_led", bus.LED_EN, 2);
        chk("m1_ch1_pga", bus.PGA_Gain, 0);
        at(83);
        chk("m1_done_pre", bus.done, 0);
        at(84);
        chk("m1_done", bus.done, 1);
        chk("m1_busy", bus.busy, 0);
        chk("m1_s0_pga", bus.PGA_Gain, 3);
        chk("m1_s0_dc", bus.DC_Comp, 64);
        at(94);
        chk("m1_s1_led", bus.LED_EN, 2);
        chk("m1_s1_pga", bus.PGA_Gain, 3);
        at(99);

        start_cal(2);
        chk("m2_dc", bus.DC_Comp, 64);
        at(7);
        chk("m2_dc_lock", bus.DC_Comp, 64);
        chk("m2_pga0", bus.PGA_Gain, 0);
        at(112);
        chk("m2_pga15", bus.PGA_Gain, 15);
        at(119);
        chk("m2_ch1_led", bus.LED_EN, 2);
        chk("m2_ch1_pga", bus.PGA_Gain, 0);
        at(237);
        chk("m2_done_pre", bus.done, 0);
        at(238);
        chk("m2_done", bus.done, 1);
        chk("m2_s0_pga", bus.PGA_Gain, 15);
        chk("m2_s0_dc", bus.DC_Comp, 64);
        chk("m2_fail", bus.cal_fail, 0);
        at(243);

        start_cal(3);
        chk("m3_dc", bus.DC_Comp, 64);
        chk("m3_fail0", bus.cal_fail, 0);
        at(7);
        chk("m3_dc_dn", bus.DC_Comp, 63);
        at(448);
        chk("m3_dc_zero", bus.DC_Comp, 0);
        at(454);
        chk("m3_fail_pre", bus.cal_fail, 0);
        at(455);
        chk("m3_fail", bus.cal_fail, 1);
        chk("m3_no_wrap", bus.DC_Comp, 0);
        chk("m3_pga0", bus.PGA_Gain, 0);
        at(567);
        chk("m3_ch1_led", bus.LED_EN, 2);
        chk("m3_ch1_dc", bus.DC_Comp, 64);
        chk("m3_ch1_fail", bus.cal_fail, 1);
        chk("m3_ch1_busy", bus.busy, 1);
        at(570);

        #2 rst_n = 1'b0;
        #1;
        chk("ar_led", bus.LED_EN, 0);
        chk("ar_dc", bus.DC_Comp, 0);
        chk("ar_pga", bus.PGA_Gain, 0);
        chk("ar_busy", bus.busy, 0);
        chk("ar_fail", bus.cal_fail, 0);
        chk("ar_clkf", bus.CLK_Filter, 0);
        @(negedge CLK);
        rst_n = 1'b1;
        repeat (5) @(negedge CLK);
        chk("ar_idle_led", bus.LED_EN, 0);
        chk("ar_idle_done", bus.done, 0);
        chk("ar_idle_dc", bus.DC_Comp, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
